// File: rtl/pc_sequencer.sv
// Program counter and next-address unit: holds the fetch PC, forms the
// sequential/branch/jump/register-jump/exception targets, arbitrates them by
// fixed priority and buffers a redirect that arrives during a stall.
//
// state | meaning
// ------+-----------------------------------------------------------------
// BOOT  | first cycle after reset release; no fetch, redirects ignored
// RUN   | normal fetch; pc advances on fetch_ready or jumps on a redirect
// HOLD  | stalled with a buffered redirect target waiting to be applied
module pc_sequencer #(
    parameter int               AW       = 32,
    parameter int               IMM_W    = 16,
    parameter int               JIDX_W   = 26,
    parameter int               SHIFT    = 2,
    parameter logic [AW-1:0]    RESET_PC = 32'h0000_0000,
    parameter logic [AW-1:0]    EXC_VEC  = 32'h0000_0080
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  imm,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jidx,
    input  logic              jr,
    input  logic [AW-1:0]     jr_target,
    input  logic              exc,
    output logic [AW-1:0]     pc,
    output logic [AW-1:0]     pc_plus4,
    output logic              fetch_valid,
    output logic              redirect_pending,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   pc_n;
    logic [AW-1:0]   pend, pend_n;
    logic            mis_n;

    logic [AW-1:0]   imm_ext;
    logic [AW-1:0]   br_tgt;
    logic [AW-1:0]   jmp_tgt;
    logic [AW-1:0]   hi_mask;
    logic            jr_bad;
    logic            evt;
    logic            jr_mis_win;
    logic [AW-1:0]   tgt;

    assign pc_plus4 = pc + (AW'(1) << SHIFT);
    assign imm_ext  = {{(AW-IMM_W){imm[IMM_W-1]}}, imm};
    assign br_tgt   = pc_plus4 + (imm_ext << SHIFT);
    // Upper bits above the jump index come from the sequential address.
    assign hi_mask  = {AW{1'b1}} << (JIDX_W + SHIFT);
    assign jmp_tgt  = (pc_plus4 & hi_mask) | (AW'(jidx) << SHIFT);
    assign jr_bad   = |jr_target[SHIFT-1:0];

    assign evt        = exc | jr | jump | branch_taken;
    assign jr_mis_win = !exc && jr && jr_bad;

    // Fixed-priority target select: exc > jr > jump > branch.
    always_comb begin
        tgt = br_tgt;
        if (exc)
            tgt = EXC_VEC;
        else if (jr)
            tgt = jr_bad ? EXC_VEC : jr_target;
        else if (jump)
            tgt = jmp_tgt;
    end

    // Next-state, next-pc and pending-target decision.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        pend_n  = pend;
        mis_n   = 1'b0;
        case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (evt) begin
                    mis_n = jr_mis_win;
                    if (stall) begin
                        pend_n  = tgt;
                        state_n = HOLD;
                    end else begin
                        pc_n = tgt;
                    end
                end else if (fetch_ready && !stall) begin
                    pc_n = pc_plus4;
                end
            end
            HOLD: begin
                if (evt)
                    mis_n = jr_mis_win;
                if (stall) begin
                    if (evt)
                        pend_n = tgt;
                end else begin
                    pc_n    = evt ? tgt : pend;
                    pend_n  = '0;
                    state_n = RUN;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    // State, pc, pending target and misalignment pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pend       <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend       <= pend_n;
            misaligned <= mis_n;
        end
    end

    assign fetch_valid      = (state != BOOT);
    assign redirect_pending = (state == HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch address.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] imm = '0;
    logic        jump = 1'b0;
    logic [25:0] jidx = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic        exc = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        misaligned;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [31:0] m_pc;
    logic        m_booted;
    logic        m_pend_v;
    logic [31:0] m_pend;
    logic        m_mis;

    pc_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .branch_taken     (branch_taken),
        .imm              (imm),
        .jump             (jump),
        .jidx             (jidx),
        .jr               (jr),
        .jr_target        (jr_target),
        .exc              (exc),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending),
        .misaligned       (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_booted = 1'b0;
        m_pend_v = 1'b0;
        m_pend   = 32'h0;
        m_mis    = 1'b0;
    endtask

    // Address the winning redirect would send the PC to, by plain arithmetic.
    function automatic logic [31:0] model_target(input logic [31:0] cur);
        longint p4;
        p4 = longint'(cur) + 4;
        if (exc) return 32'h80;
        if (jr) return (jr_target % 4 != 0) ? 32'h80 : jr_target;
        if (jump) return 32'((p4 & 64'hF000_0000) + longint'(jidx) * 4);
        return 32'(p4 + longint'($signed(imm)) * 4);
    endfunction

    task automatic model_clk();
        logic        ev;
        logic [31:0] t;
        ev = exc || jr || jump || branch_taken;
        t  = model_target(m_pc);
        if (!m_booted) begin
            m_booted = 1'b1;
            m_mis    = 1'b0;
        end else begin
            m_mis = ev && !exc && jr && (jr_target % 4 != 0);
            if (!m_pend_v) begin
                if (ev) begin
                    if (stall) begin
                        m_pend   = t;
                        m_pend_v = 1'b1;
                    end else begin
                        m_pc = t;
                    end
                end else if (fetch_ready && !stall) begin
                    m_pc = m_pc + 32'd4;
                end
            end else if (!stall) begin
                m_pc     = ev ? t : m_pend;
                m_pend_v = 1'b0;
            end else if (ev) begin
                m_pend = t;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, m_booted});
        check({tag, ".pending"}, {31'b0, redirect_pending}, {31'b0, m_pend_v});
        check({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, m_mis});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) model_clk();
        #1;
        compare_model(tag);
    endtask

    task automatic idle();
        branch_taken = 1'b0;
        jump = 1'b0;
        jr = 1'b0;
        exc = 1'b0;
        stall = 1'b0;
    endtask

    task automatic go_to(input logic [31:0] a);
        idle();
        jr = 1'b1;
        jr_target = a;
        step("goto");
        jr = 1'b0;
    endtask

    initial begin
        model_reset();
        fetch_ready = 1'b1;
        #12;
        check("reset.pc", pc, 32'h0);
        check("reset.fv", {31'b0, fetch_valid}, 32'h0);
        check("reset.pend", {31'b0, redirect_pending}, 32'h0);
        check("reset.mis", {31'b0, misaligned}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("boot.fv", {31'b0, fetch_valid}, 32'h0);
        step("boot_exit");
        check("seq0", pc, 32'h0);
        check("seq0.fv", {31'b0, fetch_valid}, 32'h1);
        step("seq1");
        check("seq1", pc, 32'h4);
        step("seq2");
        check("seq2", pc, 32'h8);

        go_to(32'h100);
        branch_taken = 1'b1; imm = 16'hFFFC;
        step("br_neg");
        check("br_neg", pc, 32'hF4);
        go_to(32'h100);
        branch_taken = 1'b1; imm = 16'h0003;
        step("br_pos");
        check("br_pos", pc, 32'h110);

        go_to(32'h1000_0000);
        jump = 1'b1; jidx = 26'h10;
        step("jump");
        check("jump", pc, 32'h1000_0040);
        jump = 1'b1; exc = 1'b1;
        step("exc_wins");
        check("exc_wins", pc, 32'h80);

        idle();
        jr = 1'b1; jr_target = 32'h2002;
        step("jr_mis");
        check("jr_mis.pc", pc, 32'h80);
        check("jr_mis.pulse", {31'b0, misaligned}, 32'h1);
        idle(); fetch_ready = 1'b0;
        step("jr_mis_end");
        check("jr_mis.end", {31'b0, misaligned}, 32'h0);
        jr = 1'b1; jr_target = 32'h2000; fetch_ready = 1'b1;
        step("jr_ok");
        check("jr_ok.pc", pc, 32'h2000);
        check("jr_ok.mis", {31'b0, misaligned}, 32'h0);

        go_to(32'h100);
        stall = 1'b1; branch_taken = 1'b1; imm = 16'h003F;
        step("hold_br");
        check("hold_br.pend", {31'b0, redirect_pending}, 32'h1);
        check("hold_br.pc", pc, 32'h100);
        branch_taken = 1'b0; jump = 1'b1; jidx = 26'hC0;
        step("hold_jmp");
        check("hold_jmp.pc", pc, 32'h100);
        idle();
        step("release");
        check("release.pc", pc, 32'h300);
        check("release.pend", {31'b0, redirect_pending}, 32'h0);

        go_to(32'h40);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("not_ready");
            check("not_ready.pc", pc, 32'h40);
        end
        fetch_ready = 1'b1;

        stall = 1'b1; branch_taken = 1'b1; imm = 16'h0010;
        step("hold_again");
        check("hold_again.pend", {31'b0, redirect_pending}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.pc", pc, 32'h0);
        check("async_rst.pend", {31'b0, redirect_pending}, 32'h0);
        check("async_rst.fv", {31'b0, fetch_valid}, 32'h0);
        model_reset();
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            stall        = ($urandom_range(0, 9) < 3);
            fetch_ready  = ($urandom_range(0, 9) < 7);
            exc          = ($urandom_range(0, 19) == 0);
            jr           = ($urandom_range(0, 9) == 0);
            jump         = ($urandom_range(0, 9) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            imm          = 16'($urandom);
            jidx         = 26'($urandom);
            jr_target    = $urandom;
            if ($urandom_range(0, 1) == 0) jr_target[1:0] = 2'b00;
            if (n == 1500) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_model("rand_rst");
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter and next-address unit for the MIPS datapath.
- Generalises the sign-extend, shift-left, mux and adder helpers into one registered block.
- Holds the PC and computes sequential, branch, jump, register-jump and exception targets. Applies them with fixed priority.
- Handshakes with instruction memory and buffers a redirect that arrives while the pipeline is stalled.

Parameters:
AW, 32, PC / address width in bits
IMM_W, 16, branch immediate width (sign-extended to AW)
JIDX_W, 26, jump index width
SHIFT, 2, word-alignment shift for branch offset and jump index; also the alignment check width
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VEC, 32'h0000_0080, exception/misalignment vector

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline hold; PC must not advance sequentially
fetch_ready  in  1  instruction memory accepts the current fetch address
branch_taken  in  1  conditional branch resolved taken
imm  in  IMM_W  branch offset, in words
jump  in  1  absolute jump (J/JAL)
jidx  in  JIDX_W  jump index
jr  in  1  register jump (JR/JALR)
jr_target  in  AW  register jump target
exc  in  1  exception request
pc  out  AW  current fetch address
pc_plus4  out  AW  pc + (1<<SHIFT), combinational from pc
fetch_valid  out  1  pc is a valid fetch request
redirect_pending  out  1  a redirect is buffered
misaligned  out  1  one-cycle pulse: jr_target low SHIFT bits nonzero

Behaviour:
- Reset (async assert, sync-released by clk):
  - pc=RESET_PC, fetch_valid=0, redirect_pending=0, misaligned=0.
  - State=BOOT.
- States:
  - BOOT: exactly one cycle after rst_n rises, then RUN. fetch_valid=0 in BOOT. Redirect inputs in BOOT are ignored.
  - RUN: fetch_valid=1.
  - HOLD: fetch_valid=1, redirect_pending=1.
- Target arithmetic, all modulo 2^AW, carries discarded:
  - seq = pc_plus4.
  - br = pc_plus4 + (sign_extend(imm) << SHIFT).
  - jmp = {pc_plus4[AW-1:JIDX_W+SHIFT], jidx, SHIFT'b0}.
  - jr: jr_target is used unchanged when aligned.
- Priority, with exactly one winner per cycle: exc > jr > jump > branch_taken > sequential.
  - exc target = EXC_VEC.
  - jr with misaligned target: target = EXC_VEC, and misaligned pulses 1 on the next cycle.
- RUN, redirect event, stall=0:
  - pc loads the winning target next cycle, regardless of fetch_ready.
  - The outstanding fetch is abandoned.
- RUN, no event: pc loads seq only when fetch_ready=1 and stall=0. Otherwise pc holds.
- RUN, redirect event, stall=1:
  - Winning target is latched into the pending register; go to HOLD. pc holds.
- HOLD:
  - A new event with stall=1 overwrites the pending target (newest wins).
  - When stall=0: pc loads the new event's target if one is present that cycle, else the pending target. Pending clears; go to RUN.
  - Sequential advance is suppressed while in HOLD.
- misaligned is a registered pulse, asserted for 1 cycle per misaligned jr that wins arbitration. It is set in the cycle the jr is latched or applied.
- Reset asserted mid-operation clears pending, state and pc immediately (async).
- Latency: redirect-to-pc is 1 cycle; stall-release-to-pc is 1 cycle.

Test Plan:
- Reset release -> pc=0x0, fetch_valid=0 for 1 cycle, then 1. With fetch_ready=1, stall=0: pc steps 0x0, 0x4, 0x8.
- pc=0x100, branch_taken=1, imm=0xFFFC -> next pc=0xF4. imm=0x0003 -> next pc=0x110.
- pc=0x1000_0000, jump=1, jidx=0x0000010 -> next pc=0x1000_0040. Same cycle exc=1 -> next pc=0x80 (exc wins).
- jr=1, jr_target=0x0000_2002 -> next pc=0x80, misaligned=1 for exactly one cycle. jr_target=0x2000 -> pc=0x2000, misaligned stays 0.
- stall=1, then branch to 0x200 -> redirect_pending=1, pc held. Then jump to 0x300 while stalled -> pending overwritten. Release stall -> next pc=0x300, pending=0.
- fetch_ready=0 for 3 cycles at pc=0x40 -> pc held at 0x40. rst_n=0 asserted while in HOLD -> pc=0x0 and pending=0 immediately, without waiting for a clk edge.
